// File: rtl/wave_pkg.sv
// Constants and FSM encoding shared by the wave generator and the wave analyzer.
package wave_pkg;

  localparam int unsigned WAVE_DATA_W   = 8;
  localparam int unsigned WAVE_PERIOD_W = 16;
  localparam int unsigned WAVE_MID      = 128;
  localparam int unsigned WAVE_HYST     = 8;

  typedef logic [2:0] wave_state_t;

  localparam wave_state_t StIdle    = 3'd0;
  localparam wave_state_t StArm     = 3'd1;
  localparam wave_state_t StSeek    = 3'd2;
  localparam wave_state_t StMeasure = 3'd3;
  localparam wave_state_t StDone    = 3'd4;

endpackage

// File: rtl/wave_analyzer_if.sv
// Sample stream in, measurement results out; master drives samples, slave measures.
interface wave_analyzer_if import wave_pkg::*; #(
  parameter int unsigned DATA_W   = WAVE_DATA_W,
  parameter int unsigned PERIOD_W = WAVE_PERIOD_W
) ();

  logic                ena;
  logic                start;
  logic [DATA_W-1:0]   sample_in;
  logic                sample_valid;
  logic                busy;
  logic                result_valid;
  logic [PERIOD_W-1:0] period;
  logic [DATA_W-1:0]   min_val;
  logic [DATA_W-1:0]   max_val;
  logic                timeout;

  modport master (
    output ena, start, sample_in, sample_valid,
    input  busy, result_valid, period, min_val, max_val, timeout
  );

  modport slave (
    input  ena, start, sample_in, sample_valid,
    output busy, result_valid, period, min_val, max_val, timeout
  );

endinterface

// File: rtl/wave_xing_detect.sv
// Hysteresis threshold compare with a registered "has been low" flag that
// qualifies the next high crossing as a genuine rising edge.
module wave_xing_detect #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned MID    = 128,
  parameter int unsigned HYST   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample,
  input  logic              clear,
  input  logic              update,
  output logic              below,
  output logic              above,
  output logic              low_armed
);

  localparam logic [DATA_W-1:0] LowThr  = DATA_W'(MID - HYST);
  localparam logic [DATA_W-1:0] HighThr = DATA_W'(MID + HYST);

  logic low_armed_q;

  assign below     = (sample <= LowThr);
  assign above     = (sample >= HighThr);
  assign low_armed = low_armed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      low_armed_q <= 1'b0;
    end else if (clear) begin
      low_armed_q <= 1'b0;
    end else if (update && below) begin
      low_armed_q <= 1'b1;
    end
  end

endmodule

// File: rtl/wave_analyzer.sv
// Measures one period of a sample stream between two hysteresis-qualified rising
// crossings and reports period plus min/max once per start request.
module wave_analyzer import wave_pkg::*; #(
  parameter int unsigned DATA_W   = WAVE_DATA_W,
  parameter int unsigned PERIOD_W = WAVE_PERIOD_W,
  parameter int unsigned MID      = WAVE_MID,
  parameter int unsigned HYST     = WAVE_HYST
) (
  input logic           clk,
  input logic           rst_n,
  wave_analyzer_if.slave bus
);

  localparam logic [PERIOD_W-1:0] CountMax = '1;

  wave_state_t         state_q, state_d;
  logic [PERIOD_W-1:0] count_q, count_d, count_inc;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [DATA_W-1:0]   min_acc_q, min_acc_d, max_acc_q, max_acc_d;
  logic [DATA_W-1:0]   min_nxt, max_nxt;
  logic [DATA_W-1:0]   min_q, min_d, max_q, max_d;
  logic                timeout_q, timeout_d;
  logic                adv, below, above, low_armed;
  logic                xing_clear, xing_update;

  // Sampling states only move on an enabled, valid sample.
  assign adv         = bus.ena && bus.sample_valid;
  assign xing_clear  = (state_q == StSeek) && adv && above;
  assign xing_update = (state_q == StMeasure) && adv;

  wave_xing_detect #(
    .DATA_W (DATA_W),
    .MID    (MID),
    .HYST   (HYST)
  ) u_xing (
    .clk       (clk),
    .rst_n     (rst_n),
    .sample    (bus.sample_in),
    .clear     (xing_clear),
    .update    (xing_update),
    .below     (below),
    .above     (above),
    .low_armed (low_armed)
  );

  assign min_nxt   = (bus.sample_in < min_acc_q) ? bus.sample_in : min_acc_q;
  assign max_nxt   = (bus.sample_in > max_acc_q) ? bus.sample_in : max_acc_q;
  assign count_inc = (count_q == CountMax) ? count_q : count_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    period_d  = period_q;
    min_acc_d = min_acc_q;
    max_acc_d = max_acc_q;
    min_d     = min_q;
    max_d     = max_q;
    timeout_d = timeout_q;
    case (state_q)
      StIdle: begin
        if (bus.ena && bus.start) begin
          state_d   = StArm;
          count_d   = '0;
          timeout_d = 1'b0;
        end
      end
      StArm: begin
        if (adv && below) state_d = StSeek;
      end
      StSeek: begin
        if (adv && above) begin
          state_d   = StMeasure;
          count_d   = '0;
          min_acc_d = bus.sample_in;
          max_acc_d = bus.sample_in;
        end
      end
      StMeasure: begin
        if (adv) begin
          count_d   = count_inc;
          min_acc_d = min_nxt;
          max_acc_d = max_nxt;
          if (low_armed && above) begin
            state_d  = StDone;
            period_d = count_q + 1'b1;
            min_d    = min_nxt;
            max_d    = max_nxt;
          end else if (count_inc == CountMax) begin
            state_d   = StDone;
            period_d  = CountMax;
            min_d     = min_nxt;
            max_d     = max_nxt;
            timeout_d = 1'b1;
          end
        end
      end
      StDone: begin
        if (bus.ena) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      count_q   <= '0;
      period_q  <= '0;
      min_acc_q <= '0;
      max_acc_q <= '0;
      min_q     <= '0;
      max_q     <= '0;
      timeout_q <= 1'b0;
    end else if (bus.ena) begin
      state_q   <= state_d;
      count_q   <= count_d;
      period_q  <= period_d;
      min_acc_q <= min_acc_d;
      max_acc_q <= max_acc_d;
      min_q     <= min_d;
      max_q     <= max_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.busy         = (state_q != StIdle);
  assign bus.result_valid = (state_q == StDone);
  assign bus.period       = period_q;
  assign bus.min_val      = min_q;
  assign bus.max_val      = max_q;
  assign bus.timeout      = timeout_q;

endmodule
